// File: rtl/ipm_distributed_pkt_fifo_v1_0.sv
// Single-clock packet FIFO on distributed RAM: words become visible to the reader
// only after their packet is committed; packets can be discarded explicitly or on overflow.
module ipm_distributed_pkt_fifo_v1_0 #(
  parameter int ADDR_WIDTH       = 6,
  parameter int DATA_WIDTH       = 32,
  parameter int ALMOST_FULL_NUM  = 4,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  wr_last,
  input  logic                  wr_drop,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_water_level,
  output logic                  ovf_drop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_water_level,
  output logic [ADDR_WIDTH:0]   pkt_cnt,
  output logic [15:0]           drop_cnt,
  output logic [1:0]            wr_state
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_PKT     = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_e;

  wr_state_e state;

  // Each entry is {last, data}; the array has no reset.
  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] commit_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] wr_level;
  logic [ADDR_WIDTH:0] rd_level;
  logic [ADDR_WIDTH:0] free_words;
  logic [DATA_WIDTH:0] head;

  logic wr_open;
  logic drop_req;
  logic wr_accept;
  logic wr_ovf;
  logic rd_accept;
  logic commit;
  logic pop_last;
  logic drop_inc;

  // Handshake: a word is written on a rising edge where wr_en=1, no wr_drop, the
  // write FSM is not discarding and full=0; a word is popped where rd_en=1 and empty=0.
  // full/empty come from registered pointers only, so there is no same-cycle bypass.
  assign wr_level   = wr_ptr - rd_ptr;
  assign rd_level   = commit_ptr - rd_ptr;
  assign free_words = DEPTH_L - wr_level;

  assign full           = (wr_level == DEPTH_L);
  assign almost_full    = (free_words <= AF_L);
  assign empty          = (rd_level == '0);
  assign almost_empty   = (rd_level <= AE_L);
  assign wr_water_level = wr_level;
  assign rd_water_level = rd_level;
  assign wr_state       = state;

  assign head    = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign rd_data = empty ? '0 : head[DATA_WIDTH-1:0];
  assign rd_last = ~empty & head[DATA_WIDTH];

  always_comb begin
    wr_open   = (state != WR_DISCARD);
    drop_req  = wr_open & wr_drop;
    wr_accept = wr_open & ~wr_drop & wr_en & ~full;
    wr_ovf    = wr_open & ~wr_drop & wr_en & full;
    rd_accept = rd_en & ~empty;
    commit    = wr_accept & wr_last;
    pop_last  = rd_accept & head[DATA_WIDTH];
    // Explicit drop only counts when a packet was actually in progress.
    drop_inc  = (drop_req & (state == WR_PKT)) | wr_ovf;
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {wr_last, wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WR_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      ovf_drop   <= 1'b0;
    end else begin
      ovf_drop <= 1'b0;

      if (drop_inc && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end

      if (rd_accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      // A commit and a last-word pop in the same cycle cancel out.
      case ({commit, pop_last})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase

      case (state)
        WR_IDLE, WR_PKT: begin
          if (wr_drop) begin
            wr_ptr <= commit_ptr;
            state  <= WR_IDLE;
          end else if (wr_accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_last) begin
              commit_ptr <= wr_ptr + 1'b1;
              state      <= WR_IDLE;
            end else begin
              state <= WR_PKT;
            end
          end else if (wr_ovf) begin
            // Roll back the partial packet; swallow its tail until wr_last.
            wr_ptr   <= commit_ptr;
            ovf_drop <= 1'b1;
            state    <= wr_last ? WR_IDLE : WR_DISCARD;
          end
        end
        WR_DISCARD: begin
          if (wr_drop || (wr_en && wr_last)) begin
            state <= WR_IDLE;
          end
        end
        default: state <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipm_distributed_pkt_fifo_v1_0.sv
// Directed bench for the packet FIFO: a table of single-cycle vectors followed by
// hand-written multi-cycle sequences checked against an expected-word queue.
module tb_ipm_distributed_pkt_fifo_v1_0;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          wr_last;
  logic          wr_drop;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_water_level;
  logic          ovf_drop;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          rd_en;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rd_water_level;
  logic [AW:0]   pkt_cnt;
  logic [15:0]   drop_cnt;
  logic [1:0]    wr_state;

  ipm_distributed_pkt_fifo_v1_0 #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ALMOST_FULL_NUM(4), .ALMOST_EMPTY_NUM(4)
  ) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_last(wr_last),
    .wr_drop(wr_drop), .full(full), .almost_full(almost_full),
    .wr_water_level(wr_water_level), .ovf_drop(ovf_drop), .rd_data(rd_data),
    .rd_last(rd_last), .rd_en(rd_en), .empty(empty), .almost_empty(almost_empty),
    .rd_water_level(rd_water_level), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
    .wr_state(wr_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [DW:0] exp_q[$];

  typedef struct {
    logic          we;
    logic          wl;
    logic          wd;
    logic          re;
    logic [31:0]   d;
    logic          e_empty;
    logic [AW:0]   e_wlvl;
    logic [AW:0]   e_rlvl;
    logic [AW:0]   e_pkt;
    logic [15:0]   e_drop;
    logic [31:0]   e_rdata;
    logic          e_rlast;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic we, logic wl, logic wd, logic re, logic [31:0] d,
                              logic e, logic [AW:0] wlv, logic [AW:0] rlv, logic [AW:0] pk,
                              logic [15:0] dc, logic [31:0] rdd, logic rl);
    vec_t v;
    v.we = we; v.wl = wl; v.wd = wd; v.re = re; v.d = d;
    v.e_empty = e; v.e_wlvl = wlv; v.e_rlvl = rlv; v.e_pkt = pk;
    v.e_drop = dc; v.e_rdata = rdd; v.e_rlast = rl;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_last = 1'b0; wr_drop = 1'b0; rd_en = 1'b0; wr_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wr_word(input logic [31:0] d, input logic last, input logic re);
    wr_en = 1'b1; wr_data = d; wr_last = last; rd_en = re;
    tick();
    idle_inputs();
  endtask

  task automatic rd_word();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic check_head(input string name);
    logic [DW:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_data"}, 64'(rd_data), 64'(e[DW-1:0]));
      check({name, "_last"}, 64'(rd_last), 64'(e[DW]));
    end
  endtask

  initial begin
    vecs[0]  = mk(1,0,0,0,32'hA1, 1,1,0,0,0,0,0);
    vecs[1]  = mk(1,0,0,0,32'hA2, 1,2,0,0,0,0,0);
    vecs[2]  = mk(1,0,0,0,32'hA3, 1,3,0,0,0,0,0);
    vecs[3]  = mk(1,0,0,0,32'hA4, 1,4,0,0,0,0,0);
    vecs[4]  = mk(1,0,0,0,32'hA5, 1,5,0,0,0,0,0);
    vecs[5]  = mk(0,0,1,0,32'h0,  1,0,0,0,1,0,0);
    vecs[6]  = mk(0,0,0,1,32'h0,  1,0,0,0,1,0,0);
    vecs[7]  = mk(0,0,1,0,32'h0,  1,0,0,0,1,0,0);
    vecs[8]  = mk(1,1,0,0,32'hB1, 0,1,1,1,1,32'hB1,1);
    vecs[9]  = mk(1,0,0,1,32'hC1, 1,1,0,0,1,0,0);
    vecs[10] = mk(1,0,1,0,32'hC2, 1,0,0,0,2,0,0);
    vecs[11] = mk(1,1,0,1,32'hD1, 0,1,1,1,2,32'hD1,1);
    vecs[12] = mk(1,0,0,1,32'hE1, 1,1,0,0,2,0,0);
    vecs[13] = mk(1,1,0,0,32'hE2, 0,2,2,1,2,32'hE1,0);
    vecs[14] = mk(0,0,0,1,32'h0,  0,1,1,1,2,32'hE2,1);
    vecs[15] = mk(1,1,0,1,32'hF1, 0,1,1,1,2,32'hF1,1);
    vecs[16] = mk(0,0,0,1,32'h0,  1,0,0,0,2,0,0);

    do_reset();
    check("rst_full", 64'(full), 64'd0);
    check("rst_almost_full", 64'(almost_full), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_almost_empty", 64'(almost_empty), 64'd1);
    check("rst_wr_level", 64'(wr_water_level), 64'd0);
    check("rst_rd_level", 64'(rd_water_level), 64'd0);
    check("rst_ovf_drop", 64'(ovf_drop), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_rd_last", 64'(rd_last), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_wr_state", 64'(wr_state), 64'd0);

    // table: partial packet + explicit drop, idle drop, interleaved read/write
    for (int i = 0; i < 17; i++) begin
      wr_en = vecs[i].we; wr_last = vecs[i].wl; wr_drop = vecs[i].wd;
      rd_en = vecs[i].re; wr_data = vecs[i].d;
      tick();
      idle_inputs();
      check($sformatf("vec%0d_empty", i), 64'(empty), 64'(vecs[i].e_empty));
      check($sformatf("vec%0d_wr_level", i), 64'(wr_water_level), 64'(vecs[i].e_wlvl));
      check($sformatf("vec%0d_rd_level", i), 64'(rd_water_level), 64'(vecs[i].e_rlvl));
      check($sformatf("vec%0d_pkt_cnt", i), 64'(pkt_cnt), 64'(vecs[i].e_pkt));
      check($sformatf("vec%0d_drop_cnt", i), 64'(drop_cnt), 64'(vecs[i].e_drop));
      check($sformatf("vec%0d_rd_data", i), 64'(rd_data), 64'(vecs[i].e_rdata));
      check($sformatf("vec%0d_rd_last", i), 64'(rd_last), 64'(vecs[i].e_rlast));
      check($sformatf("vec%0d_ovf_drop", i), 64'(ovf_drop), 64'd0);
    end

    // three 8-word packets, then drain
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int w = 0; w < 8; w++) begin
        wr_word(32'h1000 + 32'(p * 8 + w), (w == 7), 1'b0);
        exp_q.push_back({(w == 7), 32'h1000 + 32'(p * 8 + w)});
      end
    end
    check("t1_pkt_cnt", 64'(pkt_cnt), 64'd3);
    check("t1_rd_level", 64'(rd_water_level), 64'd24);
    check("t1_empty", 64'(empty), 64'd0);
    for (int i = 0; i < 24; i++) begin
      check_head($sformatf("t1_rd%0d", i));
      rd_word();
      if (i == 7) check("t1_pkt_after_first", 64'(pkt_cnt), 64'd2);
    end
    check("t1_pkt_end", 64'(pkt_cnt), 64'd0);
    check("t1_empty_end", 64'(empty), 64'd1);

    // 70-word packet overflows a 64-word FIFO
    do_reset();
    for (int i = 1; i <= 70; i++) begin
      wr_word(32'h3000 + 32'(i), (i == 70), 1'b0);
      if (i == 64) begin
        check("t3_full_64", 64'(full), 64'd1);
        check("t3_wr_level_64", 64'(wr_water_level), 64'd64);
        check("t3_empty_64", 64'(empty), 64'd1);
        check("t3_ovf_64", 64'(ovf_drop), 64'd0);
      end
      if (i == 65) begin
        check("t3_ovf_65", 64'(ovf_drop), 64'd1);
        check("t3_wr_level_65", 64'(wr_water_level), 64'd0);
        check("t3_rd_level_65", 64'(rd_water_level), 64'd0);
        check("t3_full_65", 64'(full), 64'd0);
        check("t3_state_65", 64'(wr_state), 64'd2);
      end
      if (i == 66) check("t3_ovf_66", 64'(ovf_drop), 64'd0);
    end
    check("t3_wr_level_end", 64'(wr_water_level), 64'd0);
    check("t3_drop_cnt", 64'(drop_cnt), 64'd1);
    check("t3_empty_end", 64'(empty), 64'd1);
    check("t3_state_end", 64'(wr_state), 64'd0);
    wr_word(32'h3A0, 1'b0, 1'b0); exp_q.push_back({1'b0, 32'h3A0});
    wr_word(32'h3A1, 1'b1, 1'b0); exp_q.push_back({1'b1, 32'h3A1});
    check("t3_next_pkt_cnt", 64'(pkt_cnt), 64'd1);
    check("t3_next_rd_level", 64'(rd_water_level), 64'd2);
    for (int i = 0; i < 2; i++) begin
      check_head($sformatf("t3_rd%0d", i));
      rd_word();
    end

    // back-to-back single-word packets with continuous reads
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) check_head($sformatf("t4_rd%0d", k));
      wr_word(32'h4000 + 32'(k), 1'b1, 1'b1);
      exp_q.push_back({1'b1, 32'h4000 + 32'(k)});
      check($sformatf("t4_pkt%0d", k), 64'(pkt_cnt), 64'd1);
      check($sformatf("t4_empty%0d", k), 64'(empty), 64'd0);
    end
    check_head("t4_rd_last_word");
    rd_word();
    check("t4_pkt_end", 64'(pkt_cnt), 64'd0);
    check("t4_empty_end", 64'(empty), 64'd1);

    // watermarks, then read past empty
    do_reset();
    for (int i = 1; i <= 60; i++) begin
      wr_word(32'h5000 + 32'(i), (i % 10 == 0), 1'b0);
      if (i == 59) check("t5_af_59", 64'(almost_full), 64'd0);
    end
    check("t5_af_60", 64'(almost_full), 64'd1);
    check("t5_full_60", 64'(full), 64'd0);
    check("t5_wr_level", 64'(wr_water_level), 64'd60);
    check("t5_rd_level", 64'(rd_water_level), 64'd60);
    check("t5_pkt_cnt", 64'(pkt_cnt), 64'd6);
    check("t5_ae_60", 64'(almost_empty), 64'd0);
    for (int i = 1; i <= 56; i++) begin
      rd_word();
      if (i == 55) check("t5_ae_level5", 64'(almost_empty), 64'd0);
    end
    check("t5_rd_level_4", 64'(rd_water_level), 64'd4);
    check("t5_ae_level4", 64'(almost_empty), 64'd1);
    check("t5_pkt_after_56", 64'(pkt_cnt), 64'd1);
    check("t5_head_57", 64'(rd_data), 64'h5039);
    for (int i = 0; i < 4; i++) rd_word();
    check("t5_empty", 64'(empty), 64'd1);
    rd_word();
    check("t5_rd_level_after_empty_rd", 64'(rd_water_level), 64'd0);
    check("t5_wr_level_after_empty_rd", 64'(wr_water_level), 64'd0);
    check("t5_pkt_zero", 64'(pkt_cnt), 64'd0);
    wr_word(32'h5ABC, 1'b1, 1'b0);
    check("t5_head_after_empty_rd", 64'(rd_data), 64'h5ABC);
    check("t5_rd_level_1", 64'(rd_water_level), 64'd1);

    // reset in the middle of a packet with two committed packets stored
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int w = 0; w < 3; w++) wr_word(32'h6000 + 32'(p * 3 + w), (w == 2), 1'b0);
    end
    wr_word(32'h6100, 1'b0, 1'b0);
    wr_word(32'h6101, 1'b0, 1'b0);
    check("t6_pkt_before", 64'(pkt_cnt), 64'd2);
    check("t6_wr_level_before", 64'(wr_water_level), 64'd8);
    check("t6_rd_level_before", 64'(rd_water_level), 64'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_empty", 64'(empty), 64'd1);
    check("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("t6_wr_level", 64'(wr_water_level), 64'd0);
    check("t6_rd_level", 64'(rd_water_level), 64'd0);
    check("t6_drop_cnt", 64'(drop_cnt), 64'd0);
    check("t6_rd_data", 64'(rd_data), 64'd0);
    check("t6_rd_last", 64'(rd_last), 64'd0);
    check("t6_state", 64'(wr_state), 64'd0);
    wr_drop = 1'b1;
    tick();
    idle_inputs();
    check("t6_idle_drop_cnt", 64'(drop_cnt), 64'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
